pattern_gen: RTL and testbench
==============================

PATTERN_GEN -- requirements
Module: pattern_gen

Interface
REQ-001 SHALL have parameter: WIDTH, 8, pattern length in bits (2..16).
REQ-002 SHALL have port: clock  input  1  sole clock, rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: start  input  1  transmit request, sampled only while ready=1.
REQ-005 SHALL have port: data_in  input  WIDTH  pattern word, sent MSB first.
REQ-006 SHALL have port: rpt  input  4  extra repetitions (total sends = rpt+1, i.e. 1..16).
REQ-007 SHALL have port: ready  output  1  high only in IDLE.
REQ-008 SHALL have port: x_out  output  1  serial stream; idle level 1.
REQ-009 SHALL have port: frame  output  1  high while x_out carries a pattern (or parity) bit.
REQ-010 SHALL have port: done  output  1  one-cycle pulse after the final bit of the final repetition.

Function
REQ-011 SHALL implement FSM states IDLE, SHIFT, PAR, DONE.
REQ-012 IDLE SHALL drive ready=1, x_out=1, frame=0, done=0.
REQ-013 IDLE with start=1 at a rising edge SHALL capture data_in and rpt, clear the bit counter, and enter SHIFT.
REQ-014 First bit (data_in[WIDTH-1]) SHALL appear on x_out the cycle after start is sampled (latency 1).
REQ-015 SHIFT SHALL output one bit per cycle, MSB to LSB, with frame=1; the bit counter is $clog2(WIDTH) bits wide.
REQ-016 After the LSB, SHALL go to PAR if enabled (REQ-024), else to the repeat decision.
REQ-017 Repeat decision: remaining count >0 SHALL decrement it and restart SHIFT from the captured MSB on the next cycle, with no idle gap; remaining count =0 SHALL enter DONE.
REQ-018 DONE SHALL last exactly one cycle with done=1, x_out=1, frame=0, ready=0, then return to IDLE.
REQ-019 start SHALL be ignored outside IDLE; data_in and rpt changes after capture SHALL NOT affect the frame in progress.
REQ-020 start held high continuously SHALL begin a new transmission on the first IDLE cycle after DONE, giving one idle cycle between transmissions.

Reset
REQ-021 reset=0 SHALL immediately force state IDLE, ready=1, x_out=1, frame=0, done=0, and clear counters and the shift register, independent of clock.
REQ-022 Reset asserted mid-frame SHALL abort with no done pulse; the first start after release SHALL behave exactly as after power-up.

Configuration
REQ-023 Macro PATTERN_GEN_PARITY_EN SHALL control the parity option.
REQ-024 With PATTERN_GEN_PARITY_EN defined, each repetition SHALL append one PAR cycle carrying even parity of the captured word (XOR of all bits), frame=1; each repetition then takes WIDTH+1 cycles.
REQ-025 Without the macro, the PAR state and parity logic SHALL NOT be compiled; each repetition takes WIDTH cycles.

Structure
REQ-026 State encodings (IDLE=2'b00, SHIFT=2'b01, PAR=2'b10, DONE=2'b11) and the repeat-count width constant (4) SHALL reside in shared package pattern_pkg.
REQ-027 The load/rotate shift register SHALL be a sub-module pattern_shifter (load, shift enable, reload from captured word, serial MSB out); the FSM and counters SHALL stay in pattern_gen.

Verification (WIDTH=8)
REQ-028 data_in=8'h3E, rpt=0, start pulsed at edge 0 -> x_out=0,0,1,1,1,1,1,0 at cycles 1-8 with frame=1; done=1 at cycle 9; ready=1 at cycle 10.
REQ-029 data_in=8'hA5, rpt=2 -> 24 consecutive frame=1 cycles repeating 1,0,1,0,0,1,0,1 with no gap; a single done pulse at cycle 25.
REQ-030 PATTERN_GEN_PARITY_EN defined, data_in=8'h07, rpt=0 -> 8 data bits, then x_out=1 (parity) at cycle 9 with frame=1; done at cycle 10.
REQ-031 reset driven low at cycle 4 of a frame (asynchronously, mid-cycle) -> x_out=1, frame=0, ready=1 immediately; no done pulse; next start sends the full pattern correctly.
REQ-032 start pulsed at cycle 3 of an active frame with different data_in -> ignored; the original pattern completes unchanged.
REQ-033 start held high, data_in=8'h0F, rpt=0 -> frames back to back separated by exactly one DONE cycle and one IDLE cycle.

Source files
------------

// File: rtl/pattern_pkg.sv
// Shared definitions for the pattern generator: FSM state encodings,
// the repeat-count width and the optional parity helper.
// Optional feature macro: PATTERN_GEN_PARITY_EN (appends one parity bit
// after every repetition of the pattern).
package pattern_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_PAR   = 2'b10,
        ST_DONE  = 2'b11
    } state_e;

    // Width of the extra-repetition count (total sends = rpt + 1).
    localparam int RPT_W = 4;

`ifdef PATTERN_GEN_PARITY_EN
    // Even parity over a 16-bit-capable word; unused upper bits must be zero.
    function automatic logic even_parity16(input logic [15:0] word);
        even_parity16 = ^word;
    endfunction
`endif

endpackage

// File: rtl/pattern_shifter.sv
// Load/rotate shift register for pattern_gen. Holds the captured word
// so every repetition can restart from its MSB, and exposes the MSB the
// register will hold after the current edge so the caller can register it.
// Optional feature macro: PATTERN_GEN_PARITY_EN (adds a parity output).
module pattern_shifter
    import pattern_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             shift_en,
    input  logic             reload,
    input  logic [WIDTH-1:0] data_in,
`ifdef PATTERN_GEN_PARITY_EN
    output logic             word_parity,
`endif
    output logic             msb_next
);

    logic [WIDTH-1:0] word_q;
    logic [WIDTH-1:0] word_d;
    logic [WIDTH-1:0] sh_q;
    logic [WIDTH-1:0] sh_d;

    // Next-value selection: load wins over reload, reload over shift.
    always_comb begin
        word_d = word_q;
        sh_d   = sh_q;
        if (load) begin
            word_d = data_in;
            sh_d   = data_in;
        end else if (reload) begin
            sh_d   = word_q;
        end else if (shift_en) begin
            sh_d   = {sh_q[WIDTH-2:0], 1'b0};
        end else begin
            sh_d   = sh_q;
        end
    end

    // Captured word and working shift register, cleared by reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            word_q <= '0;
            sh_q   <= '0;
        end else begin
            word_q <= word_d;
            sh_q   <= sh_d;
        end
    end

    assign msb_next = sh_d[WIDTH-1];

`ifdef PATTERN_GEN_PARITY_EN
    assign word_parity = even_parity16(16'(word_q));
`endif

endmodule

// File: rtl/pattern_gen.sv
// Serial pattern generator: sends a captured WIDTH-bit word MSB first,
// rpt+1 times back to back, then pulses done for one cycle.
// Optional feature macro: PATTERN_GEN_PARITY_EN (one even-parity bit
// appended after each repetition).
module pattern_gen
    import pattern_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    input  logic [RPT_W-1:0] rpt,
    output logic             ready,
    output logic             x_out,
    output logic             frame,
    output logic             done
);

    localparam int             CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  LAST_BIT = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [RPT_W-1:0] rem_q, rem_d;
    logic             x_out_q, x_out_d;
    logic             frame_q, frame_d;
    logic             ready_q, ready_d;
    logic             done_q, done_d;

    logic             load_s;
    logic             shift_s;
    logic             reload_s;
    logic             rep_end_s;
    logic             msb_next_s;
`ifdef PATTERN_GEN_PARITY_EN
    logic             parity_s;
`endif

    pattern_shifter #(.WIDTH(WIDTH)) u_shifter (
        .clock       (clock),
        .reset       (reset),
        .load        (load_s),
        .shift_en    (shift_s),
        .reload      (reload_s),
        .data_in     (data_in),
`ifdef PATTERN_GEN_PARITY_EN
        .word_parity (parity_s),
`endif
        .msb_next    (msb_next_s)
    );

    // Next-state, counter and shifter-control logic.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        rem_d     = rem_q;
        load_s    = 1'b0;
        shift_s   = 1'b0;
        reload_s  = 1'b0;
        rep_end_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    load_s    = 1'b1;
                    bit_cnt_d = '0;
                    rem_d     = rpt;
                    state_d   = ST_SHIFT;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (bit_cnt_q == LAST_BIT) begin
                    bit_cnt_d = '0;
`ifdef PATTERN_GEN_PARITY_EN
                    state_d   = ST_PAR;
`else
                    rep_end_s = 1'b1;
`endif
                end else begin
                    bit_cnt_d = bit_cnt_q + CW'(1);
                    shift_s   = 1'b1;
                end
            end
`ifdef PATTERN_GEN_PARITY_EN
            ST_PAR: begin
                rep_end_s = 1'b1;
            end
`endif
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Repeat decision at the end of every repetition.
        if (rep_end_s) begin
            if (rem_q != '0) begin
                rem_d    = rem_q - RPT_W'(1);
                reload_s = 1'b1;
                state_d  = ST_SHIFT;
            end else begin
                state_d  = ST_DONE;
            end
        end else begin
            reload_s = 1'b0;
        end
    end

    // Output values for the state being entered, so outputs are flops.
    always_comb begin
        x_out_d = 1'b1;
        frame_d = 1'b0;
        ready_d = (state_d == ST_IDLE);
        done_d  = (state_d == ST_DONE);
        case (state_d)
            ST_SHIFT: begin
                x_out_d = msb_next_s;
                frame_d = 1'b1;
            end
`ifdef PATTERN_GEN_PARITY_EN
            ST_PAR: begin
                x_out_d = parity_s;
                frame_d = 1'b1;
            end
`endif
            default: begin
                x_out_d = 1'b1;
                frame_d = 1'b0;
            end
        endcase
    end

    // State, counters and registered outputs; reset forces idle levels.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            rem_q     <= '0;
            x_out_q   <= 1'b1;
            frame_q   <= 1'b0;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            rem_q     <= rem_d;
            x_out_q   <= x_out_d;
            frame_q   <= frame_d;
            ready_q   <= ready_d;
            done_q    <= done_d;
        end
    end

    assign x_out = x_out_q;
    assign frame = frame_q;
    assign ready = ready_q;
    assign done  = done_q;

endmodule

// File: tb/tb_pattern_gen.sv
// Directed self-checking bench for pattern_gen (WIDTH=8).
// Honours PATTERN_GEN_PARITY_EN the same way the design does.
module tb_pattern_gen;

    logic       clock;
    logic       reset;
    logic       start;
    logic [7:0] data_in;
    logic [3:0] rpt;
    logic       ready;
    logic       x_out;
    logic       frame;
    logic       done;

    int tests_run;
    int tests_failed;

`ifdef PATTERN_GEN_PARITY_EN
    localparam int PAR_CYC = 1;
`else
    localparam int PAR_CYC = 0;
`endif

    pattern_gen #(.WIDTH(8)) dut (
        .clock   (clock),
        .reset   (reset),
        .start   (start),
        .data_in (data_in),
        .rpt     (rpt),
        .ready   (ready),
        .x_out   (x_out),
        .frame   (frame),
        .done    (done)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Pulse start so it is sampled at the next rising edge (edge 0);
    // returns 1 time unit into cycle 1.
    task automatic kick(input logic [7:0] d, input logic [3:0] r, input logic hold);
        @(negedge clock);
        data_in = d;
        rpt     = r;
        start   = 1'b1;
        @(posedge clock);
        #1;
        if (!hold) start = 1'b0;
    endtask

    // Starting in cycle 1 of a frame, check every pattern/parity cycle,
    // the done cycle, and the following idle cycle.
    task automatic expect_frame(input logic [7:0] d, input logic [3:0] r, input string tag);
        for (int rep = 0; rep <= int'(r); rep++) begin
            for (int i = 7; i >= 0; i--) begin
                tests_run++;
                if (x_out !== d[i] || frame !== 1'b1 || done !== 1'b0 || ready !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL %s rep%0d bit%0d: x_out=%b frame=%b done=%b ready=%b, want x_out=%b frame=1 done=0 ready=0",
                             tag, rep, i, x_out, frame, done, ready, d[i]);
                end
                @(posedge clock);
                #1;
            end
            if (PAR_CYC == 1) begin
                tests_run++;
                if (x_out !== (^d) || frame !== 1'b1 || done !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL %s rep%0d parity: x_out=%b frame=%b done=%b, want x_out=%b frame=1 done=0",
                             tag, rep, x_out, frame, done, ^d);
                end
                @(posedge clock);
                #1;
            end
        end
        tests_run++;
        if (done !== 1'b1 || x_out !== 1'b1 || frame !== 1'b0 || ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s done_cycle: done=%b x_out=%b frame=%b ready=%b, want 1 1 0 0",
                     tag, done, x_out, frame, ready);
        end
        @(posedge clock);
        #1;
        tests_run++;
        if (ready !== 1'b1 || done !== 1'b0 || frame !== 1'b0 || x_out !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s idle_after: ready=%b done=%b frame=%b x_out=%b, want 1 0 0 1",
                     tag, ready, done, frame, x_out);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        #2;
        reset = 1'b0;
        #2;
        tests_run++;
        if (ready !== 1'b1 || x_out !== 1'b1 || frame !== 1'b0 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_state: ready=%b x_out=%b frame=%b done=%b, want 1 1 0 0",
                     ready, x_out, frame, done);
        end
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        tests_run++;
        if (ready !== 1'b1 || x_out !== 1'b1 || frame !== 1'b0 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL idle_after_reset: ready=%b x_out=%b frame=%b done=%b, want 1 1 0 0",
                     ready, x_out, frame, done);
        end
    endtask

    task automatic test_single;
        kick(8'h3E, 4'd0, 1'b0);
        expect_frame(8'h3E, 4'd0, "single_3E");
    endtask

    task automatic test_repeat;
        kick(8'hA5, 4'd2, 1'b0);
        expect_frame(8'hA5, 4'd2, "repeat_A5");
    endtask

    task automatic test_parity;
        kick(8'h07, 4'd0, 1'b0);
        expect_frame(8'h07, 4'd0, "parity_07");
        kick(8'h01, 4'd1, 1'b0);
        expect_frame(8'h01, 4'd1, "parity_01");
    endtask

    task automatic test_reset_midframe;
        int saw_done;
        kick(8'h3E, 4'd0, 1'b0);
        // cycles 1..3
        repeat (3) begin
            @(posedge clock);
            #1;
        end
        // now in cycle 4: drop reset mid-cycle
        #3;
        reset = 1'b0;
        #1;
        tests_run++;
        if (x_out !== 1'b1 || frame !== 1'b0 || ready !== 1'b1 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL midframe_reset: x_out=%b frame=%b ready=%b done=%b, want 1 0 1 0",
                     x_out, frame, ready, done);
        end
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        saw_done = 0;
        repeat (12) begin
            @(posedge clock);
            #1;
            if (done === 1'b1) saw_done++;
        end
        tests_run++;
        if (saw_done != 0) begin
            tests_failed++;
            $display("FAIL no_done_after_abort: done pulses=%0d, want 0", saw_done);
        end
        kick(8'hC9, 4'd0, 1'b0);
        expect_frame(8'hC9, 4'd0, "after_reset_C9");
    endtask

    task automatic test_ignore_start;
        kick(8'h3E, 4'd0, 1'b0);
        fork
            expect_frame(8'h3E, 4'd0, "ignore_start");
            begin
                repeat (2) @(posedge clock);
                #2;
                start   = 1'b1;
                data_in = 8'hC3;
                rpt     = 4'd5;
                @(posedge clock);
                #2;
                start   = 1'b0;
            end
        join
    endtask

    task automatic test_back_to_back;
        kick(8'h0F, 4'd0, 1'b1);
        expect_frame(8'h0F, 4'd0, "b2b_first");
        // start still high: sampled in the idle cycle, new frame follows
        @(posedge clock);
        #1;
        start = 1'b0;
        expect_frame(8'h0F, 4'd0, "b2b_second");
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        start        = 1'b0;
        data_in      = 8'h00;
        rpt          = 4'd0;
        test_reset();
        test_single();
        test_repeat();
        test_parity();
        test_reset_midframe();
        test_ignore_start();
        test_back_to_back();
        repeat (3) @(posedge clock);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
